// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM encoding and parameter defaults.
package mult_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int WIDTH_DEF       = 16;
   localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/mult_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; zero latency, no backpressure (pure function of its inputs).
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       vld,
   output logic       winner
);

   always_comb begin
      vld    = |req;
      // Under contention the requester that did not win last time goes next.
      winner = (req == 2'b11) ? ~last_gnt : req[1];
   end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier; req->m_st 1 cycle, m_done->ack 1 cycle.
// Grants stall while the core reports not idle; optional watchdog on WAIT under MULT_TIMEOUT_EN.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [WIDTH-1:0]   op_a0,
   input  logic [WIDTH-1:0]   op_b0,
   input  logic [WIDTH-1:0]   op_a1,
   input  logic [WIDTH-1:0]   op_b1,
   output logic [1:0]         ack,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic               busy,
   output logic               m_st,
   output logic [WIDTH-1:0]   m_mplier,
   output logic [WIDTH-1:0]   m_mcand,
   input  logic [2*WIDTH-1:0] m_prod,
   input  logic               m_idle,
   input  logic               m_done
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     m_mplier_q, m_mplier_d;
   logic [WIDTH-1:0]     m_mcand_q, m_mcand_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 owner_q, owner_d;
   logic                 last_gnt_q, last_gnt_d;
   logic                 pick_vld, pick_winner;

`ifdef MULT_TIMEOUT_EN
   logic [7:0]           cnt_q, cnt_d;
   logic                 err_q, err_d;
`endif

   rr_pick2 u_pick (
      .req      (req),
      .last_gnt (last_gnt_q),
      .vld      (pick_vld),
      .winner   (pick_winner)
   );

   always_comb begin
      state_d    = state_q;
      m_mplier_d = m_mplier_q;
      m_mcand_d  = m_mcand_q;
      result_d   = result_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      m_st       = 1'b0;
      ack        = 2'b00;
`ifdef MULT_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_vld && m_idle) begin
               owner_d    = pick_winner;
               m_mplier_d = pick_winner ? op_a1 : op_a0;
               m_mcand_d  = pick_winner ? op_b1 : op_b0;
               state_d    = START;
            end
         end
         START: begin
            m_st    = 1'b1;
            state_d = WAIT;
`ifdef MULT_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (m_done) begin
               result_d = m_prod;
               state_d  = RESP;
            end
`ifdef MULT_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            ack        = owner_q ? 2'b10 : 2'b01;
            last_gnt_d = owner_q;
            state_d    = IDLE;
`ifdef MULT_TIMEOUT_EN
            err_d      = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         m_mplier_q <= '0;
         m_mcand_q  <= '0;
         result_q   <= '0;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         m_mplier_q <= m_mplier_d;
         m_mcand_q  <= m_mcand_d;
         result_q   <= result_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
      end
   end

`ifdef MULT_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy     = (state_q != IDLE);
   assign result   = result_q;
   assign m_mplier = m_mplier_q;
   assign m_mcand  = m_mcand_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter with a bench-side multiplier core and a timestamp-based reference model.
`timescale 1ns/1ps
module tb_mult_arbiter;

   localparam int W  = 16;
   localparam int TO = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [1:0]     req = 2'b00;
   logic [W-1:0]   op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
   logic [1:0]     ack;
   logic [2*W-1:0] result;
   logic           err, busy, m_st;
   logic [W-1:0]   m_mplier, m_mcand;
   logic [2*W-1:0] m_prod = '0;
   logic           m_idle = 1'b1;
   logic           m_done = 1'b0;

   int checks   = 0;
   int failures = 0;

   mult_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .req(req),
      .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
      .ack(ack), .result(result), .err(err), .busy(busy),
      .m_st(m_st), .m_mplier(m_mplier), .m_mcand(m_mcand),
      .m_prod(m_prod), .m_idle(m_idle), .m_done(m_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Bench multiplier core: product after 1..5 cycles, random not-idle stalls and stray done pulses when free.
   int             core_cnt = 0;
   int             core_lat_fix = 0;
   bit             core_hang = 0;
   logic [2*W-1:0] core_p = '0;

   always @(posedge clk) begin
      #1;
      m_done = 1'b0;
      m_idle = 1'b1;
      m_prod = 32'($urandom);
      if (!rst) begin
         core_cnt = 0;
      end else if (m_st) begin
         core_p   = 32'(m_mplier) * 32'(m_mcand);
         core_cnt = core_hang ? 1000000 : (core_lat_fix > 0 ? core_lat_fix : int'($urandom_range(1, 5)));
         m_idle   = 1'b0;
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) begin
            m_done = 1'b1;
            m_prod = core_p;
         end else begin
            m_idle = 1'b0;
         end
      end else begin
         if ($urandom_range(0, 9) == 0) m_idle = 1'b0;
         if ($urandom_range(0, 19) == 0) m_done = 1'b1;
      end
   end

   // Reference model: one operation described by its grant cycle and done cycle.
   bit             mdl_on = 0;
   int             cyc = 0;
   bit             act = 0;
   int             t_g = 0, t_d = -1;
   bit             own = 0, last = 1;
   logic [W-1:0]   e_a = '0, e_b = '0;
   logic [2*W-1:0] e_res = '0;
   bit             e_err = 0;

   always @(negedge clk) begin
      logic [1:0] e_ack;
      if (mdl_on) begin
         e_ack = (act && t_d >= 0 && cyc == t_d + 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
         chk("busy", busy, act);
         chk("m_st", m_st, act && cyc == t_g + 1);
         chk("ack", ack, e_ack);
         chk("err", err, e_err && e_ack != 2'b00);
         chk("result", result, e_res);
         chk("m_mplier", m_mplier, e_a);
         chk("m_mcand", m_mcand, e_b);
         if (e_ack != 2'b00 && !e_err) chk("product", result, 32'(e_a) * 32'(e_b));

         if (!rst) begin
            act = 0; last = 1; e_a = '0; e_b = '0; e_res = '0; e_err = 0;
         end else if (!act) begin
            if (req != 2'b00 && m_idle) begin
               act   = 1;
               t_g   = cyc;
               t_d   = -1;
               e_err = 0;
               own   = (req == 2'b11) ? !last : req[1];
               e_a   = own ? op_a1 : op_a0;
               e_b   = own ? op_b1 : op_b0;
            end
         end else if (t_d < 0) begin
            if (cyc >= t_g + 2 && m_done) begin
               t_d   = cyc;
               e_res = m_prod;
            end
`ifdef MULT_TIMEOUT_EN
            else if (cyc == t_g + 2 + TO - 1) begin
               t_d   = cyc;
               e_res = '0;
               e_err = 1;
            end
`endif
         end else if (cyc == t_d + 1) begin
            act  = 0;
            last = own;
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic wait_ack(input string name, output logic [1:0] a, output int n);
      a = 2'b00;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         n++;
         if (ack != 2'b00) begin
            a = ack;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s: no ack within 300 cycles", name);
   endtask

   task automatic wait_st(input string name);
      for (int i = 0; i < 300; i++) begin
         step();
         if (m_st) return;
      end
      checks++;
      failures++;
      $display("FAIL %s: no m_st within 300 cycles", name);
   endtask

   function automatic logic [W-1:0] rnd_op();
      int k;
      k = int'($urandom_range(0, 9));
      if (k == 0) return 16'hFFFF;
      if (k == 1) return 16'h0000;
      return W'($urandom);
   endfunction

   initial begin
      logic [1:0] a;
      int         n;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      mdl_on = 1;
      chk("reset_ack", ack, 2'b00);
      chk("reset_result", result, 32'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_m_st", m_st, 1'b0);
      chk("reset_m_mplier", m_mplier, 16'd0);
      step();
      rst = 1'b1;

      // Single requester
      req = 2'b01; op_a0 = 16'd3; op_b0 = 16'd7;
      wait_st("single_st");
      chk("single_mplier", m_mplier, 16'd3);
      chk("single_mcand", m_mcand, 16'd7);
      wait_ack("single", a, n);
      chk("single_ack", a, 2'b01);
      chk("single_result", result, 32'd21);
      req = 2'b00;

      // Contention from reset, back-to-back alternation
      do_reset();
      req = 2'b11; op_a0 = 16'd2; op_b0 = 16'd5; op_a1 = 16'd4; op_b1 = 16'd6;
      for (int k = 0; k < 4; k++) begin
         wait_ack("contend", a, n);
         chk("contend_ack", a, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("contend_result", result, (k % 2 == 0) ? 32'd10 : 32'd24);
      end
      req = 2'b00;

      // Boundary operands
      step();
      req = 2'b01; op_a0 = 16'hFFFF; op_b0 = 16'hFFFF;
      wait_ack("max", a, n);
      chk("max_result", result, 32'hFFFE0001);
      req = 2'b10; op_a1 = 16'h0000; op_b1 = 16'h1234;
      wait_ack("zero", a, n);
      chk("zero_ack", a, 2'b10);
      chk("zero_result", result, 32'd0);
      req = 2'b00;

      // Operand change after grant
      step();
      core_lat_fix = 4;
      req = 2'b01; op_a0 = 16'd9; op_b0 = 16'd5;
      wait_st("late_st");
      op_a0 = 16'd1;
      wait_ack("late", a, n);
      chk("late_result", result, 32'd45);
      chk("late_mplier", m_mplier, 16'd9);
      req = 2'b00;

      // Reset during WAIT
      step();
      core_lat_fix = 10;
      req = 2'b01; op_a0 = 16'd7; op_b0 = 16'd7;
      wait_st("rst_st");
      step();
      step();
      rst = 1'b0; req = 2'b00;
      step();
      rst = 1'b1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ack", ack, 2'b00);
      chk("midrst_m_st", m_st, 1'b0);
      chk("midrst_result", result, 32'd0);
      core_lat_fix = 0;
      req = 2'b10; op_a1 = 16'd11; op_b1 = 16'd13;
      wait_ack("after_rst", a, n);
      chk("after_rst_ack", a, 2'b10);
      chk("after_rst_result", result, 32'd143);
      req = 2'b00;

`ifdef MULT_TIMEOUT_EN
      step();
      core_hang = 1;
      req = 2'b01; op_a0 = 16'd5; op_b0 = 16'd5;
      wait_st("to_st");
      wait_ack("timeout", a, n);
      chk("timeout_wait_cycles", n, TO + 1);
      chk("timeout_err", err, 1'b1);
      chk("timeout_result", result, 32'd0);
      req = 2'b00;
      step();
      chk("timeout_err_clear", err, 1'b0);
      core_hang = 0;
      do_reset();
`endif

      // Randomized traffic with sporadic resets
      for (int c = 0; c < 3000; c++) begin
         step();
         rst = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < 2; i++) begin
            if (ack[i] || !req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[i] = 1'b1;
                  if (i == 0) begin op_a0 = rnd_op(); op_b0 = rnd_op(); end
                  else        begin op_a1 = rnd_op(); op_b1 = rnd_op(); end
               end else if (ack[i]) begin
                  req[i] = 1'b0;
               end
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) op_a0 = rnd_op();
            else                           op_b1 = rnd_op();
         end
      end
      rst = 1'b1;
      req = 2'b00;
      repeat (20) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
